avaliador_fitness: RTL and testbench

Sequential fitness evaluator that drives one `fenotipo` instance. It latches a candidate chromosome and a target truth table, then sweeps every input combination on `chromIn`. For each combination it waits a programmable settle time, samples `chromOut`, and counts the output bits that match the target. It sits between the GA population/selection logic and the evolvable circuit, and is the only block that writes the circuit configuration.

---
 rtl/avaliador_fitness_if.sv | 46 ++++
 rtl/avaliador_fitness.sv | 146 ++++++++++++++
 tb/tb_avaliador_fitness.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avaliador_fitness_if.sv
// Request/result and fenotipo-side bundle of the fitness evaluator.
// erro_mask exists only when AVALIADOR_MASCARA_EN is defined.
interface avaliador_fitness_if #(
  parameter int CHROM_W = 330,
  parameter int N_IN    = 2,
  parameter int N_OUT   = 1
);
  localparam int N_VEC  = 2 ** N_IN;
  localparam int ALVO_W = N_VEC * N_OUT;
  localparam int FIT_W  = $clog2(ALVO_W + 1);

  logic               start;
  logic [CHROM_W-1:0] cromossomo_in;
  logic [ALVO_W-1:0]  alvo;
  logic [CHROM_W-1:0] cromossomo;
  logic [N_IN-1:0]    chromIn;
  logic [N_OUT-1:0]   chromOut;
  logic               busy;
  logic               done;
  logic [FIT_W-1:0]   fitness;
`ifdef AVALIADOR_MASCARA_EN
  logic [ALVO_W-1:0]  erro_mask;

  modport slave (
    input  start, cromossomo_in, alvo, chromOut,
    output cromossomo, chromIn, busy, done,
    output fitness, erro_mask
  );
  modport master (
    output start, cromossomo_in, alvo, chromOut,
    input  cromossomo, chromIn, busy, done,
    input  fitness, erro_mask
  );
`else
  modport slave (
    input  start, cromossomo_in, alvo, chromOut,
    output cromossomo, chromIn, busy, done,
    output fitness
  );
  modport master (
    output start, cromossomo_in, alvo, chromOut,
    input  cromossomo, chromIn, busy, done,
    input  fitness
  );
`endif
endinterface

// File: rtl/avaliador_fitness.sv
// Sweeps all fenotipo inputs and counts outputs matching the target table.
// Optional AVALIADOR_MASCARA_EN adds a per-bit mismatch mask output.
module avaliador_fitness #(
  parameter int CHROM_W = 330,
  parameter int N_IN    = 2,
  parameter int N_OUT   = 1,
  parameter int SETTLE  = 2
) (
  input logic clk,
  input logic reset,
  avaliador_fitness_if.slave bus
);
  localparam int N_VEC  = 2 ** N_IN;
  localparam int ALVO_W = N_VEC * N_OUT;
  localparam int FIT_W  = $clog2(ALVO_W + 1);
  localparam int CNT_W  = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [FIT_W-1:0]   acc_q, acc_d;
  logic [FIT_W-1:0]   fit_q, fit_d;
  logic [CHROM_W-1:0] chrom_q, chrom_d;
  logic [ALVO_W-1:0]  alvo_q, alvo_d;
  logic [N_OUT-1:0]   entry;
  logic [N_OUT-1:0]   miss;
  logic [FIT_W-1:0]   hits;
`ifdef AVALIADOR_MASCARA_EN
  logic [ALVO_W-1:0]  wmask_q, wmask_d;
  logic [ALVO_W-1:0]  emask_q, emask_d;
`endif

  assign entry = alvo_q[vec_q*N_OUT +: N_OUT];
  assign miss  = bus.chromOut ^ entry;

  always_comb begin
    hits = '0;
    for (int k = 0; k < N_OUT; k++) begin
      hits = hits + FIT_W'(~miss[k]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    acc_d   = acc_q;
    fit_d   = fit_q;
    chrom_d = chrom_q;
    alvo_d  = alvo_q;
`ifdef AVALIADOR_MASCARA_EN
    wmask_d = wmask_q;
    emask_d = emask_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          chrom_d = bus.cromossomo_in;
          alvo_d  = bus.alvo;
          acc_d   = '0;
          vec_d   = '0;
          cnt_d   = CNT_W'(SETTLE);
          state_d = S_WAIT;
`ifdef AVALIADOR_MASCARA_EN
          wmask_d = '0;
`endif
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        acc_d = acc_q + hits;
`ifdef AVALIADOR_MASCARA_EN
        wmask_d[vec_q*N_OUT +: N_OUT] = miss;
`endif
        if (&vec_q) begin
          fit_d   = acc_d;
          state_d = S_DONE;
`ifdef AVALIADOR_MASCARA_EN
          emask_d = wmask_d;
`endif
        end else begin
          vec_d   = vec_q + N_IN'(1);
          cnt_d   = CNT_W'(SETTLE);
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      acc_q   <= '0;
      fit_q   <= '0;
      chrom_q <= '0;
      alvo_q  <= '0;
`ifdef AVALIADOR_MASCARA_EN
      wmask_q <= '0;
      emask_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      acc_q   <= acc_d;
      fit_q   <= fit_d;
      chrom_q <= chrom_d;
      alvo_q  <= alvo_d;
`ifdef AVALIADOR_MASCARA_EN
      wmask_q <= wmask_d;
      emask_q <= emask_d;
`endif
    end
  end

  assign bus.cromossomo = chrom_q;
  assign bus.chromIn    = vec_q;
  assign bus.fitness    = fit_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.busy       = (state_q == S_WAIT) ||
                          (state_q == S_SAMPLE);
`ifdef AVALIADOR_MASCARA_EN
  assign bus.erro_mask  = emask_q;
`endif

endmodule

// File: tb/tb_avaliador_fitness.sv
// Directed bench for avaliador_fitness with an XOR / constant fenotipo model.
// Mask checks are compiled in only with AVALIADOR_MASCARA_EN.
module tb_avaliador_fitness;
  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   mode = 1'b0;
  int   checks = 0;
  int   failures = 0;

  localparam logic [329:0] CA = {11{30'h2AAA_5555}};
  localparam logic [329:0] CB = {11{30'h1234_5678}};

  logic [1:0]   rec_ci   [0:13];
  logic         rec_busy [0:13];
  logic         rec_done [0:13];
  logic [2:0]   rec_fit  [0:13];
  logic [329:0] rec_chr  [0:13];

  avaliador_fitness_if #(
    .CHROM_W(330), .N_IN(2), .N_OUT(1)
  ) bus ();

  avaliador_fitness #(
    .CHROM_W(330), .N_IN(2), .N_OUT(1), .SETTLE(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.chromOut = mode ? 1'b1 : (bus.chromIn[0] ^ bus.chromIn[1]);
  end

  task automatic launch(input logic [329:0] c, input logic [3:0] a);
    @(negedge clk);
    bus.start = 1'b1;
    bus.cromossomo_in = c;
    bus.alvo = a;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic watch();
    for (int k = 0; k < 14; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      rec_ci[k]   = bus.chromIn;
      rec_busy[k] = bus.busy;
      rec_done[k] = bus.done;
      rec_fit[k]  = bus.fitness;
      rec_chr[k]  = bus.cromossomo;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.cromossomo_in = CA;
    bus.alvo = 4'b0110;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%0b exp=0", bus.done);
    end
    checks++;
    if (bus.fitness !== 3'd0) begin
      failures++; $display("FAIL reset_fitness got=%0d exp=0", bus.fitness);
    end
    checks++;
    if (bus.chromIn !== 2'd0) begin
      failures++; $display("FAIL reset_chromIn got=%0d exp=0", bus.chromIn);
    end
    checks++;
    if (bus.cromossomo !== 330'd0) begin
      failures++; $display("FAIL reset_cromossomo got=%h exp=0", bus.cromossomo);
    end
`ifdef AVALIADOR_MASCARA_EN
    checks++;
    if (bus.erro_mask !== 4'b0000) begin
      failures++; $display("FAIL reset_mask got=%b exp=0000", bus.erro_mask);
    end
`endif
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_start_dropped busy=%0b exp=0", bus.busy);
    end
  endtask

  task automatic test_xor_match();
    mode = 1'b0;
    launch(CA, 4'b0110);
    watch();
    for (int k = 0; k < 14; k++) begin
      logic [1:0] eci;
      eci = (k < 12) ? 2'(k / 3) : 2'd3;
      checks++;
      if ({rec_ci[k], rec_busy[k], rec_done[k]} !== {eci, k < 12, k == 12}) begin
        failures++;
        $display("FAIL xor_seq k=%0d ci/busy/done got=%0d/%0b/%0b exp=%0d/%0b/%0b",
                 k, rec_ci[k], rec_busy[k], rec_done[k], eci, k < 12, k == 12);
      end
    end
    checks++;
    if (rec_fit[11] !== 3'd0) begin
      failures++; $display("FAIL xor_fit_hold got=%0d exp=0", rec_fit[11]);
    end
    checks++;
    if (bus.fitness !== 3'd4) begin
      failures++; $display("FAIL xor_fitness got=%0d exp=4", bus.fitness);
    end
    checks++;
    if (rec_chr[6] !== CA) begin
      failures++; $display("FAIL xor_cromossomo got=%h exp=%h", rec_chr[6], CA);
    end
`ifdef AVALIADOR_MASCARA_EN
    checks++;
    if (bus.erro_mask !== 4'b0000) begin
      failures++; $display("FAIL xor_mask got=%b exp=0000", bus.erro_mask);
    end
`endif
  endtask

  task automatic test_xor_inverse();
    mode = 1'b0;
    launch(CB, 4'b1001);
    watch();
    checks++;
    if (rec_fit[11] !== 3'd4) begin
      failures++; $display("FAIL inv_fit_hold got=%0d exp=4", rec_fit[11]);
    end
    checks++;
    if (rec_done[12] !== 1'b1 || rec_done[11] !== 1'b0) begin
      failures++; $display("FAIL inv_done_edge got=%0b%0b exp=01", rec_done[11], rec_done[12]);
    end
    checks++;
    if (rec_fit[12] !== 3'd0) begin
      failures++; $display("FAIL inv_fitness got=%0d exp=0", rec_fit[12]);
    end
`ifdef AVALIADOR_MASCARA_EN
    checks++;
    if (bus.erro_mask !== 4'b1111) begin
      failures++; $display("FAIL inv_mask got=%b exp=1111", bus.erro_mask);
    end
`endif
  endtask

  task automatic test_back_to_back();
    mode = 1'b1;
    launch(CA, 4'b0111);
    watch();
    checks++;
    if (bus.fitness !== 3'd3) begin
      failures++; $display("FAIL b2b_fitness1 got=%0d exp=3", bus.fitness);
    end
`ifdef AVALIADOR_MASCARA_EN
    checks++;
    if (bus.erro_mask !== 4'b1000) begin
      failures++; $display("FAIL b2b_mask1 got=%b exp=1000", bus.erro_mask);
    end
`endif
    launch(CB, 4'b0110);
    watch();
    checks++;
    if (rec_busy[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_accept busy=%0b exp=1", rec_busy[0]);
    end
    checks++;
    if (rec_done[12] !== 1'b1 || rec_done[11] !== 1'b0 || rec_done[13] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done got=%0b%0b%0b exp=010", rec_done[11], rec_done[12], rec_done[13]);
    end
    checks++;
    if (rec_fit[12] !== 3'd2) begin
      failures++; $display("FAIL b2b_fitness2 got=%0d exp=2", rec_fit[12]);
    end
    checks++;
    if (rec_chr[12] !== CB) begin
      failures++; $display("FAIL b2b_cromossomo got=%h exp=%h", rec_chr[12], CB);
    end
`ifdef AVALIADOR_MASCARA_EN
    checks++;
    if (bus.erro_mask !== 4'b1001) begin
      failures++; $display("FAIL b2b_mask2 got=%b exp=1001", bus.erro_mask);
    end
`endif
  endtask

  task automatic test_start_ignored();
    int ndone;
    int bad_chr;
    mode = 1'b0;
    ndone = 0;
    bad_chr = 0;
    launch(CB, 4'b0110);
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
      if (bus.cromossomo !== CB) bad_chr++;
      if (k == 4) begin
        bus.start = 1'b1;
        bus.cromossomo_in = CA;
        bus.alvo = 4'b0000;
      end
      if (k == 5) bus.start = 1'b0;
    end
    checks++;
    if (ndone !== 1) begin
      failures++; $display("FAIL ign_done_count got=%0d exp=1", ndone);
    end
    checks++;
    if (bad_chr !== 0) begin
      failures++; $display("FAIL ign_cromossomo changed_cycles=%0d exp=0", bad_chr);
    end
    checks++;
    if (bus.fitness !== 3'd4) begin
      failures++; $display("FAIL ign_fitness got=%0d exp=4", bus.fitness);
    end
  endtask

  task automatic test_reset_abort();
    int ndone;
    int wait_n;
    mode = 1'b1;
    launch(CA, 4'b0111);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.fitness, bus.chromIn} !== 7'd0) begin
      failures++;
      $display("FAIL abort_outputs busy/done/fit/ci got=%0b/%0b/%0d/%0d exp=0/0/0/0",
               bus.busy, bus.done, bus.fitness, bus.chromIn);
    end
    checks++;
    if (bus.cromossomo !== 330'd0) begin
      failures++; $display("FAIL abort_cromossomo got=%h exp=0", bus.cromossomo);
    end
    reset = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++; $display("FAIL abort_no_done got=%0d exp=0", ndone);
    end
    launch(CB, 4'b0111);
    wait_n = 0;
    while (!bus.done && wait_n < 30) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    checks++;
    if (wait_n !== 12) begin
      failures++; $display("FAIL abort_restart_latency got=%0d exp=12", wait_n);
    end
    checks++;
    if (bus.fitness !== 3'd3) begin
      failures++; $display("FAIL abort_restart_fitness got=%0d exp=3", bus.fitness);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cromossomo_in = '0;
    bus.alvo = '0;
    test_reset();
    test_xor_match();
    test_xor_inverse();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
